mem_align_seq: RTL

MEM_ALIGN_SEQ -- requirements
Module: mem_align_seq

---
 rtl/mem_align_seq.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/mem_align_seq.sv
// Memory alignment sequencer: turns byte/half/word/dword accesses into one or two bus-aligned beats
// and merges/extends load data. Optional macro MEM_ALIGN_TRAP_EN traps misaligned accesses instead of splitting.
module mem_align_seq #(
    parameter int BUS_BYTES = 4,
    parameter int ADDR_W    = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [ADDR_W-1:0]      req_addr,
    input  logic [1:0]             req_size,
    input  logic                   req_we,
    input  logic                   req_signed,
    input  logic [8*BUS_BYTES-1:0] req_wdata,
    output logic                   mem_valid,
    input  logic                   mem_ready,
    output logic [ADDR_W-1:0]      mem_addr,
    output logic [BUS_BYTES-1:0]   mem_we,
    output logic                   mem_re,
    output logic [8*BUS_BYTES-1:0] mem_wdata,
    input  logic [8*BUS_BYTES-1:0] mem_rdata,
    output logic                   resp_valid,
    output logic [8*BUS_BYTES-1:0] resp_rdata,
    output logic                   resp_err,
    output logic                   resp_split,
    output logic                   misalign_exc,
    output logic                   busy
);
    localparam int DW    = 8 * BUS_BYTES;
    localparam int MW    = 2 * BUS_BYTES;
    localparam int OFF_W = $clog2(BUS_BYTES);

    typedef enum logic [2:0] {IDLE, BEAT0, BEAT1, RDWAIT, RESP} state_t;

    // Byte-enable pattern across two consecutive bus words; upper half belongs to the second beat.
    function automatic logic [MW-1:0] lane_mask(input logic [1:0] size, input logic [OFF_W-1:0] off);
        logic [MW-1:0] m;
        m = '0;
        for (int i = 0; i < MW; i++)
            if (i < (1 << size)) m[i] = 1'b1;
        return m << off;
    endfunction

    function automatic logic [2*DW-1:0] lane_data(input logic [DW-1:0] d, input logic [OFF_W-1:0] off);
        logic [2*DW-1:0] w;
        w = {{DW{1'b0}}, d};
        return w << (8 * off);
    endfunction

    function automatic logic [DW-1:0] merge_load(input logic [DW-1:0] rd0, input logic [DW-1:0] rd1,
                                                 input logic [OFF_W-1:0] off, input logic [1:0] size,
                                                 input logic sgn);
        logic [DW-1:0] raw;
        logic [DW-1:0] res;
        logic          s;
        raw = (rd0 >> (8 * off)) | (rd1 << (8 * (BUS_BYTES - int'(off))));
        res = '0;
        s   = 1'b0;
        for (int b = 0; b < BUS_BYTES; b++) begin
            if (b < (1 << size)) res[8*b +: 8] = raw[8*b +: 8];
            if (b == (1 << size) - 1) s = sgn & raw[8*b+7];
        end
        for (int b = 0; b < BUS_BYTES; b++)
            if (b >= (1 << size)) res[8*b +: 8] = {8{s}};
        return res;
    endfunction

    state_t            state_q, state_d;
    logic              split_q, split_d;
    logic              err_q, err_d;
    logic              trap_q, trap_d;
    logic              squash_q, squash_d;
    logic              rd_pend_q, rd_pend_d;
    logic [DW-1:0]     resp_rdata_q, resp_rdata_d;

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        size_q, size_d;
    logic              we_q, we_d;
    logic              sgn_q, sgn_d;
    logic [DW-1:0]     wdata_q, wdata_d;
    logic [DW-1:0]     rd0_q, rd0_d;

    logic [OFF_W-1:0]  off_in;
    logic              illegal_in, split_in, trap_in;
    logic [OFF_W-1:0]  cur_off;
    logic [ADDR_W-1:0] cur_base;
    logic [MW-1:0]     cur_mask;
    logic [2*DW-1:0]   cur_wide;

    assign off_in     = req_addr[OFF_W-1:0];
    assign illegal_in = (1 << req_size) > BUS_BYTES;
    assign split_in   = (int'(off_in) + (1 << req_size)) > BUS_BYTES;
`ifdef MEM_ALIGN_TRAP_EN
    assign trap_in    = !illegal_in && ((int'(off_in) & ((1 << req_size) - 1)) != 0);
`else
    assign trap_in    = 1'b0;
`endif

    assign cur_off  = addr_q[OFF_W-1:0];
    assign cur_base = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    assign cur_mask = lane_mask(size_q, cur_off);
    assign cur_wide = lane_data(wdata_q, cur_off);

    // Flush wins over a simultaneous request, so the handshake never completes in that cycle.
    assign req_ready  = (state_q == IDLE) && !flush;
    assign busy       = (state_q != IDLE);
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_valid && err_q;
    assign resp_split = resp_valid && split_q;
`ifdef MEM_ALIGN_TRAP_EN
    assign misalign_exc = (state_q == RESP) && trap_q;
`else
    assign misalign_exc = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        split_d      = split_q;
        err_d        = err_q;
        trap_d       = trap_q;
        squash_d     = squash_q;
        rd_pend_d    = rd_pend_q;
        resp_rdata_d = resp_rdata_q;
        addr_d       = addr_q;
        size_d       = size_q;
        we_d         = we_q;
        sgn_d        = sgn_q;
        wdata_d      = wdata_q;
        rd0_d        = rd0_q;
        mem_valid    = 1'b0;
        mem_addr     = '0;
        mem_we       = '0;
        mem_re       = 1'b0;
        mem_wdata    = '0;
        resp_valid   = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_valid && !flush) begin
                    addr_d    = req_addr;
                    size_d    = req_size;
                    we_d      = req_we;
                    sgn_d     = req_signed;
                    wdata_d   = req_wdata;
                    err_d     = illegal_in;
                    trap_d    = trap_in;
                    split_d   = !illegal_in && !trap_in && split_in;
                    squash_d  = 1'b0;
                    rd_pend_d = 1'b0;
                    state_d   = (illegal_in || trap_in) ? RESP : BEAT0;
                end
            end
            BEAT0: begin
                mem_valid = 1'b1;
                mem_addr  = cur_base;
                mem_re    = !we_q;
                mem_we    = cur_mask[BUS_BYTES-1:0] & {BUS_BYTES{we_q}};
                mem_wdata = cur_wide[DW-1:0];
                if (mem_ready) begin
                    if (flush) squash_d = 1'b1;
                    rd_pend_d = !we_q && split_q;
                    state_d   = split_q ? BEAT1 : (we_q ? RESP : RDWAIT);
                end else if (flush) begin
                    state_d = IDLE;
                end
            end
            BEAT1: begin
                mem_valid = 1'b1;
                mem_addr  = cur_base + ADDR_W'(BUS_BYTES);
                mem_re    = !we_q;
                mem_we    = cur_mask[MW-1:BUS_BYTES] & {BUS_BYTES{we_q}};
                mem_wdata = cur_wide[2*DW-1:DW];
                // First-beat read data arrives one cycle after its acceptance, possibly while this beat stalls.
                if (rd_pend_q) begin
                    rd0_d     = mem_rdata;
                    rd_pend_d = 1'b0;
                end
                if (flush) squash_d = 1'b1;
                if (mem_ready) state_d = we_q ? RESP : RDWAIT;
            end
            RDWAIT: begin
                if (flush) squash_d = 1'b1;
                if (!squash_q && !flush)
                    resp_rdata_d = merge_load(split_q ? rd0_q : mem_rdata, split_q ? mem_rdata : '0,
                                              cur_off, size_q, sgn_q);
                state_d = RESP;
            end
            RESP: begin
                resp_valid = !trap_q && !squash_q && !flush;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            split_q      <= 1'b0;
            err_q        <= 1'b0;
            trap_q       <= 1'b0;
            squash_q     <= 1'b0;
            rd_pend_q    <= 1'b0;
            resp_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            split_q      <= split_d;
            err_q        <= err_d;
            trap_q       <= trap_d;
            squash_q     <= squash_d;
            rd_pend_q    <= rd_pend_d;
            resp_rdata_q <= resp_rdata_d;
        end
    end

    always_ff @(posedge clk) begin
        addr_q  <= addr_d;
        size_q  <= size_d;
        we_q    <= we_d;
        sgn_q   <= sgn_d;
        wdata_q <= wdata_d;
        rd0_q   <= rd0_d;
    end

endmodule
